// File: rtl/asm_deframer_pkg.sv
// Shared types and frame-geometry helpers for the ASM deframer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package asm_deframer_pkg;

    localparam logic [31:0] SYNC_MARKER_DEFAULT = 32'h1ACFFC1D;
    localparam int          PAYLOAD_LEN_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } state_e;

    // Pad bytes that round marker + payload up to a whole number of words.
    function automatic int padding_len(input int payload_len);
        return (4 - ((4 + payload_len) % 4)) % 4;
    endfunction

    function automatic int frame_words(input int payload_len);
        return (payload_len + padding_len(payload_len)) / 4;
    endfunction

endpackage

// File: rtl/asm_word_to_byte.sv
// 32->8 serializer: holds one word, emits bytes MSB first, drops frame pad, flags frame end.
// Latency: first byte valid the cycle after word_load.
// Backpressure: byte_rdy low freezes byte output; word_rdy also high while the last byte leaves.
module asm_word_to_byte
    import asm_deframer_pkg::*;
#(
    parameter int PAYLOAD_LEN = PAYLOAD_LEN_DEFAULT
) (
    input  logic        core_clk,
    input  logic        rst_n,
    input  logic        word_load,
    input  logic [31:0] word_dat,
    input  logic        word_last,
    output logic        word_rdy,
    output logic        held_empty,
    output logic [7:0]  byte_dat,
    output logic        byte_vld,
    output logic        byte_last,
    input  logic        byte_rdy
);

    localparam int         PAD          = padding_len(PAYLOAD_LEN);
    localparam logic [1:0] LAST_IDX_PAD = 2'(3 - PAD);

    logic [31:0] held_dat;
    logic        held_vld;
    logic        held_last;
    logic [1:0]  byte_idx;
    logic [1:0]  last_idx;
    logic        byte_fire;
    logic        word_done;

    // The final word of a frame stops early so its pad bytes never appear.
    assign last_idx   = held_last ? LAST_IDX_PAD : 2'd3;
    assign byte_fire  = held_vld && byte_rdy;
    assign word_done  = byte_fire && (byte_idx == last_idx);
    assign word_rdy   = !held_vld || word_done;
    assign held_empty = !held_vld;
    assign byte_vld   = held_vld;
    assign byte_last  = held_vld && held_last && (byte_idx == LAST_IDX_PAD);

    always_comb begin
        byte_dat = 8'd0;
        if (held_vld) begin
            case (byte_idx)
                2'd0:    byte_dat = held_dat[31:24];
                2'd1:    byte_dat = held_dat[23:16];
                2'd2:    byte_dat = held_dat[15:8];
                default: byte_dat = held_dat[7:0];
            endcase
        end
    end

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            held_dat  <= 32'd0;
            held_vld  <= 1'b0;
            held_last <= 1'b0;
            byte_idx  <= 2'd0;
        end else if (word_load) begin
            held_dat  <= word_dat;
            held_vld  <= 1'b1;
            held_last <= word_last;
            byte_idx  <= 2'd0;
        end else if (byte_fire) begin
            if (word_done) begin
                held_vld <= 1'b0;
            end else begin
                byte_idx <= byte_idx + 2'd1;
            end
        end
    end

endmodule

// File: rtl/asm_deframer.sv
// Attached-sync-marker deframer: hunts the marker, flywheels through misses, emits RS codeword bytes.
// Latency: payload byte valid one cycle after its word is accepted; no bubbles within a frame.
// Backpressure: m_axis tready stalls bytes and input; marker slot waits for the holder to drain. Macro ASM_BIT_TOL_EN.
module asm_deframer
    import asm_deframer_pkg::*;
#(
    parameter logic [31:0] SYNC_MARKER = SYNC_MARKER_DEFAULT,
    parameter int          PAYLOAD_LEN = PAYLOAD_LEN_DEFAULT,
    parameter int          LOSS_THRESH = 3,
    parameter int          MARKER_TOL  = 2
) (
    input  logic        core_clk,
    input  logic        rst_n,
    input  logic [31:0] s_axis_input_tdata,
    input  logic        s_axis_input_tvalid,
    input  logic        s_axis_input_tlast,
    output logic        s_axis_input_tready,
    output logic [7:0]  m_axis_output_tdata,
    output logic        m_axis_output_tvalid,
    output logic        m_axis_output_tlast,
    input  logic        m_axis_output_tready,
    output logic        sync_locked,
    output logic        marker_miss
);

    localparam int                FRAME_WORDS = frame_words(PAYLOAD_LEN);
    localparam logic [6:0]        LAST_WORD   = 7'(FRAME_WORDS - 1);
    localparam int                MISS_W      = $clog2(LOSS_THRESH + 1);
    localparam logic [MISS_W-1:0] MISS_LIMIT  = MISS_W'(LOSS_THRESH);

    state_e            state_q, state_d;
    logic [6:0]        word_cnt_q, word_cnt_d;
    logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;
    logic              locked_q, locked_d;
    logic              miss_pulse_q, miss_pulse_d;
    logic              rst_done_q;

    logic              in_fire;
    logic              marker_exact;
    logic              marker_ok;
    logic              word_load;
    logic              word_last;
    logic              word_rdy;
    logic              held_empty;
    logic              unused_cfg;

    assign unused_cfg = ^{s_axis_input_tlast, 32'(MARKER_TOL)};

    assign marker_exact = (s_axis_input_tdata == SYNC_MARKER);

`ifdef ASM_BIT_TOL_EN
    // Hunt stays exact; only the in-lock check forgives a few flipped bits.
    logic [5:0] marker_errs;
    assign marker_errs = 6'($countones(s_axis_input_tdata ^ SYNC_MARKER));
    assign marker_ok   = (marker_errs <= 6'(MARKER_TOL));
`else
    assign marker_ok   = marker_exact;
`endif

    assign in_fire = s_axis_input_tvalid && s_axis_input_tready;

    always_comb begin
        state_d             = state_q;
        word_cnt_d          = word_cnt_q;
        miss_cnt_d          = miss_cnt_q;
        locked_d            = locked_q;
        miss_pulse_d        = 1'b0;
        word_load           = 1'b0;
        word_last           = 1'b0;
        s_axis_input_tready = 1'b0;
        case (state_q)
            ST_HUNT: begin
                s_axis_input_tready = rst_done_q;
                if (in_fire && marker_exact) begin
                    state_d    = ST_PAYLOAD;
                    word_cnt_d = 7'd0;
                    miss_cnt_d = '0;
                    locked_d   = 1'b1;
                end
            end
            ST_PAYLOAD: begin
                s_axis_input_tready = rst_done_q && word_rdy;
                if (in_fire) begin
                    word_load  = 1'b1;
                    word_last  = (word_cnt_q == LAST_WORD);
                    word_cnt_d = word_cnt_q + 7'd1;
                    if (word_cnt_q == LAST_WORD) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                s_axis_input_tready = rst_done_q && held_empty;
                if (in_fire) begin
                    word_cnt_d = 7'd0;
                    if (marker_ok) begin
                        state_d    = ST_PAYLOAD;
                        miss_cnt_d = '0;
                    end else begin
                        miss_pulse_d = 1'b1;
                        // Counter saturates at the limit; it is cleared on the next lock.
                        if (miss_cnt_q >= MISS_LIMIT - 1'b1) begin
                            state_d    = ST_HUNT;
                            miss_cnt_d = MISS_LIMIT;
                            locked_d   = 1'b0;
                        end else begin
                            state_d    = ST_PAYLOAD;
                            miss_cnt_d = miss_cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d  = ST_HUNT;
                locked_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HUNT;
            word_cnt_q   <= 7'd0;
            miss_cnt_q   <= '0;
            locked_q     <= 1'b0;
            miss_pulse_q <= 1'b0;
            rst_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            locked_q     <= locked_d;
            miss_pulse_q <= miss_pulse_d;
            rst_done_q   <= 1'b1;
        end
    end

    assign sync_locked = locked_q;
    assign marker_miss = miss_pulse_q;

    asm_word_to_byte #(
        .PAYLOAD_LEN (PAYLOAD_LEN)
    ) u_word_to_byte (
        .core_clk   (core_clk),
        .rst_n      (rst_n),
        .word_load  (word_load),
        .word_dat   (s_axis_input_tdata),
        .word_last  (word_last),
        .word_rdy   (word_rdy),
        .held_empty (held_empty),
        .byte_dat   (m_axis_output_tdata),
        .byte_vld   (m_axis_output_tvalid),
        .byte_last  (m_axis_output_tlast),
        .byte_rdy   (m_axis_output_tready)
    );

endmodule

// File: tb/tb_asm_deframer.sv
// Randomized scoreboard bench for asm_deframer against a frame-level reference model.
module tb_asm_deframer;

    localparam logic [31:0] SYNC = 32'h1ACFFC1D;
    localparam int          PL   = 255;
    localparam int          FW   = (PL + 3) / 4;
    localparam int          LOSS = 3;
    localparam int          TOL  = 2;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;

    logic        core_clk = 1'b0;
    logic        rst_n    = 1'b0;
    logic [31:0] s_tdata  = 32'd0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast  = 1'b0;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready = 1'b1;
    logic        sync_locked;
    logic        marker_miss;

    always #5 core_clk = ~core_clk;

    asm_deframer dut (
        .core_clk             (core_clk),
        .rst_n                (rst_n),
        .s_axis_input_tdata   (s_tdata),
        .s_axis_input_tvalid  (s_tvalid),
        .s_axis_input_tlast   (s_tlast),
        .s_axis_input_tready  (s_tready),
        .m_axis_output_tdata  (m_tdata),
        .m_axis_output_tvalid (m_tvalid),
        .m_axis_output_tlast  (m_tlast),
        .m_axis_output_tready (m_tready),
        .sync_locked          (sync_locked),
        .marker_miss          (marker_miss)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] stim[$];
    logic [31:0] in_q[$];
    exp_t        exp_q[$];

    bit   rand_valid = 0;
    bit   rand_mrdy  = 0;
    bit   bubble_en  = 0;
    int   miss_seen  = 0;
    int   bubbles    = 0;
    int   byte_cnt   = 0;
    bit   drv_hs     = 0;
    bit   mon_stall  = 0;
    bit   mon_in_frame = 0;
    logic [7:0] mon_sd = 8'd0;
    logic       mon_sl = 1'b0;
    exp_t mon_e;
    int   m_misses;
    bit   m_locked;
    int   wait_n;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endfunction

    function automatic bit marker_good(input logic [31:0] w);
`ifdef ASM_BIT_TOL_EN
        return $countones(w ^ SYNC) <= TOL;
`else
        return w == SYNC;
`endif
    endfunction

    // Frame-level reference: scan for the marker, take FW words per frame,
    // judge each following marker slot, drop lock after LOSS consecutive bad slots.
    task automatic model_run(input logic [31:0] w[$], output int misses, output bit locked);
        int i;
        int fails;
        exp_t e;
        logic [31:0] wd;
        i = 0; fails = 0; misses = 0; locked = 0;
        while (i < w.size()) begin
            if (!locked) begin
                if (w[i] == SYNC) begin
                    locked = 1;
                    fails  = 0;
                end
                i++;
            end else begin
                for (int k = 0; k < PL; k++) begin
                    if (i + k / 4 >= w.size()) break;
                    wd  = w[i + k / 4];
                    e.d = wd[31 - 8 * (k % 4) -: 8];
                    e.l = (k == PL - 1);
                    exp_q.push_back(e);
                end
                i += FW;
                if (i < w.size()) begin
                    if (marker_good(w[i])) begin
                        fails = 0;
                    end else begin
                        misses++;
                        fails++;
                        if (fails == LOSS) locked = 0;
                    end
                    i++;
                end
            end
        end
    endtask

    task automatic add_frame(input logic [31:0] marker, input bit ramp);
        logic [31:0] word;
        logic [7:0]  b;
        int          k;
        stim.push_back(marker);
        for (int w = 0; w < FW; w++) begin
            word = 32'd0;
            for (int j = 0; j < 4; j++) begin
                k = 4 * w + j;
                if (ramp) b = (k < PL) ? 8'(k) : 8'h00;
                else      b = 8'($urandom_range(0, 255));
                word = {word[23:0], b};
            end
            stim.push_back(word);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        in_q.delete();
        exp_q.delete();
        repeat (3) @(negedge core_clk);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_sync_locked", sync_locked, 0);
        chk("rst_marker_miss", marker_miss, 0);
        rst_n = 1'b1;
    endtask

    task automatic run_phase(input string name, input bit do_rst, input bit rv, input bit rm, input bit bub);
        int misses;
        bit locked;
        int n;
        if (do_rst) apply_reset();
        miss_seen  = 0;
        bubbles    = 0;
        byte_cnt   = 0;
        rand_valid = rv;
        rand_mrdy  = rm;
        bubble_en  = bub;
        model_run(stim, misses, locked);
        foreach (stim[i]) in_q.push_back(stim[i]);
        stim.delete();
        n = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && n < 30000) begin
            @(negedge core_clk);
            n++;
        end
        rand_mrdy = 0;
        repeat (8) @(negedge core_clk);
        chk({name, "_drained"}, exp_q.size() + in_q.size(), 0);
        chk({name, "_marker_miss_count"}, miss_seen, misses);
        chk({name, "_sync_locked"}, sync_locked, locked);
        if (bub) chk({name, "_bubbles"}, bubbles, 0);
        rand_valid = 0;
        bubble_en  = 0;
    endtask

    // Input driver: pops a word only after the handshake seen mid-cycle.
    initial begin
        forever begin
            @(negedge core_clk);
            drv_hs = s_tvalid && s_tready;
            @(posedge core_clk);
            #1;
            if (drv_hs && in_q.size() > 0) void'(in_q.pop_front());
            if (in_q.size() > 0 && (!rand_valid || $urandom_range(0, 2) != 0)) begin
                s_tvalid = 1'b1;
                s_tdata  = in_q[0];
            end else begin
                s_tvalid = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge core_clk);
            #1;
            m_tready = rand_mrdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor / scoreboard.
    initial begin
        forever begin
            @(negedge core_clk);
            if (!rst_n) begin
                mon_stall    = 0;
                mon_in_frame = 0;
            end else begin
                if (mon_stall) begin
                    chk("stall_tvalid", m_tvalid, 1);
                    chk("stall_tdata", m_tdata, mon_sd);
                    chk("stall_tlast", m_tlast, mon_sl);
                end
                if (bubble_en && mon_in_frame && m_tready && !m_tvalid) bubbles++;
                if (m_tvalid && m_tready) begin
                    byte_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_byte actual=0x%0h last=%0b required=none", m_tdata, m_tlast);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("byte_tdata", m_tdata, mon_e.d);
                        chk("byte_tlast", m_tlast, mon_e.l);
                    end
                    mon_in_frame = !m_tlast;
                end
                mon_stall = m_tvalid && !m_tready;
                mon_sd    = m_tdata;
                mon_sl    = m_tlast;
                if (marker_miss) miss_seen++;
            end
        end
    end

    initial begin
        add_frame(SYNC, 1);
        run_phase("ramp", 1, 0, 0, 1);
        chk("ramp_bytes", byte_cnt, PL);

        stim.push_back(32'h12345678);
        stim.push_back(32'hFFFFFFFF);
        stim.push_back(32'h1ACFFC1C);
        repeat (20) add_frame(SYNC, 0);
        run_phase("b2b", 1, 0, 0, 1);
        chk("b2b_bytes", byte_cnt, 20 * PL);

        repeat (4) add_frame(SYNC, 0);
        run_phase("stall", 1, 1, 1, 0);
        chk("stall_bytes", byte_cnt, 4 * PL);

        add_frame(SYNC, 0);
        add_frame(32'h1ACFFC1C, 0);
        add_frame(SYNC, 0);
        run_phase("onebad", 1, 0, 0, 0);
        chk("onebad_bytes", byte_cnt, 3 * PL);

        add_frame(SYNC, 0);
        repeat (3) add_frame(32'hDEADBEEF, 0);
        run_phase("loss", 1, 0, 0, 0);
        chk("loss_bytes", byte_cnt, 3 * PL);

        // Reset in the middle of a frame, then recover on a fresh frame.
        apply_reset();
        byte_cnt = 0;
        add_frame(SYNC, 0);
        model_run(stim, m_misses, m_locked);
        foreach (stim[i]) in_q.push_back(stim[i]);
        stim.delete();
        wait_n = 0;
        while (byte_cnt < 100 && wait_n < 2000) begin
            @(negedge core_clk);
            wait_n++;
        end
        chk("midrst_reached_byte100", (byte_cnt >= 100), 1);
        #1;
        rst_n = 1'b0;
        in_q.delete();
        exp_q.delete();
        #1;
        chk("midrst_m_tvalid", m_tvalid, 0);
        chk("midrst_m_tlast", m_tlast, 0);
        chk("midrst_m_tdata", m_tdata, 0);
        chk("midrst_s_tready", s_tready, 0);
        chk("midrst_sync_locked", sync_locked, 0);
        @(negedge core_clk);
        rst_n = 1'b1;
        stim.push_back(32'hCAFEF00D);
        add_frame(SYNC, 0);
        run_phase("recover", 0, 0, 0, 1);
        chk("recover_bytes", byte_cnt, PL);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/asm_deframer.md
ASM_DEFRAMER -- requirements
Module: asm_deframer

Interface
REQ-001 Parameter SYNC_MARKER, default 32'h1ACFFC1D, is the attached sync marker expected at the head of each frame.
REQ-002 Parameter PAYLOAD_LEN, default 255, is the RS codeword bytes per frame.
REQ-003 Parameter LOSS_THRESH, default 3, is the number of consecutive missed markers in lock before returning to hunt.
REQ-004 Parameter MARKER_TOL, default 2, is the maximum marker bit errors tolerated in lock (used only with ASM_BIT_TOL_EN).
REQ-005 core_clk  input  1  sole clock; all logic is rising-edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 s_axis_input_tdata  input  32  framed word stream; byte [31:24] is first in time.
REQ-008 s_axis_input_tvalid  input  1  input word valid.
REQ-009 s_axis_input_tlast  input  1  ignored.
REQ-010 s_axis_input_tready  output  1  input word accepted when high with tvalid.
REQ-011 m_axis_output_tdata  output  8  payload byte.
REQ-012 m_axis_output_tvalid  output  1  payload byte valid.
REQ-013 m_axis_output_tlast  output  1  marks byte PAYLOAD_LEN-1 of a frame.
REQ-014 m_axis_output_tready  input  1  downstream accepts byte.
REQ-015 sync_locked  output  1  high while in LOCK.
REQ-016 marker_miss  output  1  one-cycle pulse per marker slot failing the check while locked.

Function
REQ-017 PADDING_LEN = (4-((4+PAYLOAD_LEN)%4))%4; frame = 1 marker word + FRAME_WORDS=(PAYLOAD_LEN+PADDING_LEN)/4 payload words (defaults: 1 pad byte, 64 words).
REQ-018 States: HUNT, PAYLOAD, CHECK; sync_locked = (miss-qualified lock flag), set on HUNT exit, cleared on HUNT entry.
REQ-019 HUNT: tready=1; each accepted word compared exactly to SYNC_MARKER; match -> PAYLOAD, word counter=0, miss counter=0; no output produced.
REQ-020 PAYLOAD: each accepted word loads a 32-bit holding register; bytes emitted MSB first, one per m_axis handshake.
REQ-021 Pad bytes (last PADDING_LEN bytes of last payload word) are never emitted; tlast=1 on byte PAYLOAD_LEN-1 only.
REQ-022 s_axis_input_tready in PAYLOAD = holding register empty, or last emittable byte of held word handshaking this cycle (zero-bubble at full rate).
REQ-023 Latency: first byte of a word valid on m_axis the cycle after that word is accepted.
REQ-024 After FRAME_WORDS-th payload word accepted -> CHECK.
REQ-025 CHECK: tready=1 only once holding register drained; accepted word matched -> PAYLOAD, miss counter=0.
REQ-026 CHECK mismatch: marker_miss pulse, miss counter+1; if counter reaches LOSS_THRESH -> HUNT (word discarded), else -> PAYLOAD (flywheel, frame still emitted).
REQ-027 m_axis_output_tdata/tlast held stable while tvalid=1 and tready=0.
REQ-028 Word counter 7 bits, byte index 2 bits, miss counter ceil(log2(LOSS_THRESH+1)) bits, no wrap beyond threshold.

Reset
REQ-029 rst_n low: state HUNT, all counters 0, holding register empty; m_axis_output_tvalid, tlast, tdata, sync_locked, marker_miss = 0; s_axis_input_tready = 0 during reset.
REQ-030 Reset mid-frame discards the partial frame; no tlast emitted for it; first post-reset frame requires fresh HUNT match.

Configuration
REQ-031 Macro ASM_BIT_TOL_EN defined: CHECK accepts marker if Hamming distance to SYNC_MARKER <= MARKER_TOL; HUNT remains exact.
REQ-032 ASM_BIT_TOL_EN undefined: CHECK requires exact match; MARKER_TOL unused; no popcount logic synthesized.

Structure
REQ-033 Package asm_deframer_pkg holds SYNC_MARKER default, PAYLOAD_LEN default, PADDING_LEN/FRAME_WORDS functions, state enum.
REQ-034 Sub-module asm_word_to_byte implements the 32->8 holding register, byte index, pad-drop and tlast insertion.

Verification
REQ-035 Reset, then 1ACFFC1D + 64 words bytes 0x00..0xFE,0x00 at full rate -> 255 bytes 0x00..0xFE, tlast on 0xFE, pad not output, sync_locked=1.
REQ-036 3 junk words before marker -> junk dropped, frame output intact; 20 back-to-back frames -> 5100 bytes, tready never low in PAYLOAD with m tready=1.
REQ-037 m_axis_output_tready toggling 1/0 random -> byte order and values unchanged, tdata stable during stall.
REQ-038 Locked, one marker 1ACFFC1C -> marker_miss pulse (no pulse with ASM_BIT_TOL_EN), frame still output; three consecutive bad markers -> HUNT, sync_locked=0, third frame not output.
REQ-039 rst_n pulsed low at byte 100 -> outputs zero immediately, no tlast; next valid frame fully recovered.
